// File: rtl/utxd_crc_bl.sv
// ---------------------------------------------------------------------------
// utxd_crc_bl -- serial block transmitter with trailing CRC-16.
//
// On an accepted st the block header (com, lbl, adr[15:8], adr[7:0]) is
// sent. Read commands (8'h80, 8'h81) add lbl data bytes fetched from a
// synchronous-read memory. Every block ends with CRC[7:0] then CRC[15:8].
// Each byte is framed as start 0, 8 data bits LSB first, and stop 1. Each
// bit lasts `Nt clocks. Bytes are sent back-to-back, and GAP_BITS idle bit
// periods follow the last byte.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   st          one-clock start request (ignored while en_tx_bl is high)
//   com/lbl/adr command, length and base address, sampled on accepted st
//   rd_dat      memory data, one clock after rd_adr
//   rd_adr      memory read address
//   UTXD        registered serial output, idle high
//   en_tx_bl    block in progress (accepted st .. ok_tx_bl inclusive)
//   en_tx_byte  high during start/data/stop bits
//   ok_tx_bl    one-clock pulse at the end of the guard gap
//   cb_byte     index of the byte being sent (0 = com), wraps modulo 256
// ---------------------------------------------------------------------------
`ifndef Nt
`define Nt 4
`endif
`ifndef INIT_CRC
`define INIT_CRC 16'hFFFF
`endif
`ifndef XCRC16
`define XCRC16 16'h4002
`endif

module utxd_crc_bl #(
    parameter int GAP_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic [7:0]  com,
    input  logic [7:0]  lbl,
    input  logic [15:0] adr,
    input  logic [7:0]  rd_dat,
    output logic [15:0] rd_adr,
    output logic        UTXD,
    output logic        en_tx_bl,
    output logic        en_tx_byte,
    output logic        ok_tx_bl,
    output logic [7:0]  cb_byte
);

    localparam int NT       = `Nt;
    localparam int GAP_CLKS = GAP_BITS * NT;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] nt_cnt_q, nt_cnt_d;      // clock within the current bit
    logic [3:0]  bit_cnt_q, bit_cnt_d;    // 0 start, 1..8 data, 9 stop
    logic [8:0]  byte_idx_q, byte_idx_d;  // unwrapped byte index (up to 260)
    logic [7:0]  shift_q, shift_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  com_q, com_d;
    logic [7:0]  lbl_q, lbl_d;
    logic [15:0] adr_q, adr_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] rd_adr_q, rd_adr_d;
    logic        utxd_q, utxd_d;
    logic        en_tx_bl_q, en_tx_bl_d;
    logic        en_tx_byte_q, en_tx_byte_d;
    logic        ok_q, ok_d;
    logic [7:0]  cb_byte_q, cb_byte_d;

    logic [8:0]  n_data;
    logic [8:0]  nxt_idx;
    logic        nxt_is_data;
    logic [7:0]  nxt_byte;
    logic        x0;

    // Only read commands carry a data payload.
    assign n_data = (com_q == 8'h80 || com_q == 8'h81) ? {1'b0, lbl_q} : 9'd0;

    // Selects the byte that follows the current one. Data bytes come straight
    // from rd_dat. rd_adr has been stable for a whole byte time, so the
    // memory output is already valid.
    always_comb begin
        nxt_idx     = byte_idx_q + 9'd1;
        nxt_is_data = (nxt_idx >= 9'd4) && (nxt_idx < 9'd4 + n_data);
        nxt_byte    = crc_q[15:8];
        if (nxt_idx == 9'd1)                nxt_byte = lbl_q;
        else if (nxt_idx == 9'd2)           nxt_byte = adr_q[15:8];
        else if (nxt_idx == 9'd3)           nxt_byte = adr_q[7:0];
        else if (nxt_is_data)               nxt_byte = rd_dat;
        else if (nxt_idx == 9'd4 + n_data)  nxt_byte = crc_q[7:0];
    end

    assign x0 = crc_q[0] ^ shift_q[0];

    always_comb begin
        state_d      = state_q;
        nt_cnt_d     = nt_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        crc_d        = crc_q;
        com_d        = com_q;
        lbl_d        = lbl_q;
        adr_d        = adr_q;
        gap_cnt_d    = gap_cnt_q;
        rd_adr_d     = rd_adr_q;
        utxd_d       = utxd_q;
        en_tx_bl_d   = en_tx_bl_q;
        en_tx_byte_d = en_tx_byte_q;
        ok_d         = 1'b0;
        cb_byte_d    = cb_byte_q;

        if (st && !en_tx_bl_q) begin
            // The start bit of com goes out on the next clock.
            state_d      = S_SEND;
            nt_cnt_d     = '0;
            bit_cnt_d    = '0;
            byte_idx_d   = '0;
            shift_d      = com;
            crc_d        = `INIT_CRC;
            com_d        = com;
            lbl_d        = lbl;
            adr_d        = adr;
            rd_adr_d     = adr;
            utxd_d       = 1'b0;
            en_tx_bl_d   = 1'b1;
            en_tx_byte_d = 1'b1;
            cb_byte_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Reached in the ok_tx_bl cycle, so en_tx_bl drops one clock later.
                    en_tx_bl_d = 1'b0;
                    utxd_d     = 1'b1;
                end
                S_SEND: begin
                    if (nt_cnt_q == 16'(NT - 1)) begin
                        nt_cnt_d = '0;
                        if (bit_cnt_q == 4'd9) begin
                            if (byte_idx_q == 9'd5 + n_data) begin
                                state_d      = S_GAP;
                                gap_cnt_d    = '0;
                                en_tx_byte_d = 1'b0;
                                utxd_d       = 1'b1;
                            end else begin
                                byte_idx_d = nxt_idx;
                                cb_byte_d  = cb_byte_q + 8'd1;
                                bit_cnt_d  = '0;
                                utxd_d     = 1'b0;
                                shift_d    = nxt_byte;
                                if (nxt_is_data) rd_adr_d = rd_adr_q + 16'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd8) begin
                                utxd_d = 1'b1;
                            end else begin
                                utxd_d  = shift_q[0];
                                shift_d = {1'b0, shift_q[7:1]};
                                // CRC covers header and data bits, never the CRC bytes.
                                if (byte_idx_q < 9'd4 + n_data)
                                    crc_d = x0 ? (((crc_q ^ 16'(`XCRC16)) >> 1) | 16'h8000)
                                               : (crc_q >> 1);
                            end
                        end
                    end else begin
                        nt_cnt_d = nt_cnt_q + 16'd1;
                    end
                end
                S_GAP: begin
                    utxd_d = 1'b1;
                    if (gap_cnt_q == 32'(GAP_CLKS - 1)) begin
                        ok_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nt_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            crc_q        <= `INIT_CRC;
            com_q        <= '0;
            lbl_q        <= '0;
            adr_q        <= '0;
            gap_cnt_q    <= '0;
            rd_adr_q     <= '0;
            utxd_q       <= 1'b1;
            en_tx_bl_q   <= 1'b0;
            en_tx_byte_q <= 1'b0;
            ok_q         <= 1'b0;
            cb_byte_q    <= '0;
        end else begin
            state_q      <= state_d;
            nt_cnt_q     <= nt_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            crc_q        <= crc_d;
            com_q        <= com_d;
            lbl_q        <= lbl_d;
            adr_q        <= adr_d;
            gap_cnt_q    <= gap_cnt_d;
            rd_adr_q     <= rd_adr_d;
            utxd_q       <= utxd_d;
            en_tx_bl_q   <= en_tx_bl_d;
            en_tx_byte_q <= en_tx_byte_d;
            ok_q         <= ok_d;
            cb_byte_q    <= cb_byte_d;
        end
    end

    assign rd_adr     = rd_adr_q;
    assign UTXD       = utxd_q;
    assign en_tx_bl   = en_tx_bl_q;
    assign en_tx_byte = en_tx_byte_q;
    assign ok_tx_bl   = ok_q;
    assign cb_byte    = cb_byte_q;

endmodule

// File: tb/tb_utxd_crc_bl.sv
// Bench for utxd_crc_bl. The driver builds each expected block (header,
// memory data and CRC) from the transmission rules and queues it. A
// line-level monitor decodes UTXD into bytes and compares them against
// the queue. It also checks timing, rd_adr, and the CRC residue a receiver
// would compute.
`ifndef Nt
`define Nt 4
`endif
`ifndef INIT_CRC
`define INIT_CRC 16'hFFFF
`endif
`ifndef XCRC16
`define XCRC16 16'h4002
`endif

module tb_utxd_crc_bl;
    localparam int NT = `Nt;
    localparam int GB = 12;
    localparam int G  = GB * NT;

    logic        clk = 1'b0;
    logic        rst, st;
    logic [7:0]  com, lbl, rd_dat;
    logic [15:0] adr, rd_adr;
    logic        UTXD, en_tx_bl, en_tx_byte, ok_tx_bl;
    logic [7:0]  cb_byte;

    utxd_crc_bl #(.GAP_BITS(GB)) dut (
        .clk(clk), .rst(rst), .st(st), .com(com), .lbl(lbl), .adr(adr),
        .rd_dat(rd_dat), .rd_adr(rd_adr), .UTXD(UTXD), .en_tx_bl(en_tx_bl),
        .en_tx_byte(en_tx_byte), .ok_tx_bl(ok_tx_bl), .cb_byte(cb_byte)
    );

    // clock / cycle counter / memory model
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:65535];
    always @(posedge clk) rd_dat <= mem[rd_adr];

    // scoreboard state
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    int          exp_start_q[$];
    logic [15:0] exp_rdadr_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b1;
    bit mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Receiver-side CRC rule: bit enters LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = ((r ^ 16'(`XCRC16)) >> 1) | 16'h8000;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // monitor
    task automatic get_byte(input int idx, output logic [7:0] b, output int c, output bit got);
        got = 1'b0;
        b   = '0;
        c   = 0;
        for (int k = 0; k < 12 * NT && !got; k++) begin
            if (UTXD === 1'b0) got = 1'b1;
            else @(negedge clk);
        end
        if (got) begin
            c = cyc;
            chk("cb_byte", {24'd0, cb_byte}, 32'(idx & 255));
            chk("en_tx_byte", {31'd0, en_tx_byte}, 32'd1);
            for (int j = 0; j < 8; j++) begin
                repeat (NT) @(negedge clk);
                b[j] = UTXD;
            end
            repeat (NT) @(negedge clk);
            chk("stop_bit", {31'd0, UTXD}, 32'd1);
        end
    endtask

    task automatic run_block();
        int          len, c0, last_c, c;
        logic [15:0] erd, rcrc;
        logic [7:0]  b, e;
        bit          got, found;
        mon_busy = 1'b1;
        len    = exp_len_q.pop_front();
        c0     = (exp_start_q.size() > 0) ? exp_start_q.pop_front() : -1;
        erd    = exp_rdadr_q.pop_front();
        rcrc   = `INIT_CRC;
        last_c = 0;
        got    = 1'b1;
        for (int i = 0; i < len && got; i++) begin
            get_byte(i, b, c, got);
            if (!got) begin
                chk("byte_start_timeout", 32'd0, 32'd1);
            end else begin
                if (i == 0) chk("first_start_cycle", 32'(c), 32'(c0));
                else        chk("byte_period", 32'(c - last_c), 32'(10 * NT));
                last_c = c;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("byte_value", {24'd0, b}, {24'd0, e});
                rcrc = crc_byte(rcrc, b);
            end
        end
        if (got) begin
            chk("rx_crc_residue", {16'd0, rcrc}, 32'd0);
            found = 1'b0;
            for (int k = 0; k < G + 20 * NT && !found; k++) begin
                if (ok_tx_bl === 1'b1) found = 1'b1;
                else @(negedge clk);
            end
            chk("ok_tx_bl_seen", {31'd0, found}, 32'd1);
            if (found) begin
                chk("ok_tx_bl_cycle", 32'(cyc), 32'(last_c + 10 * NT + G));
                chk("rd_adr_end", {16'd0, rd_adr}, {16'd0, erd});
                chk("en_tx_bl_at_ok", {31'd0, en_tx_bl}, 32'd1);
                @(negedge clk);
                chk("ok_tx_bl_pulse", {31'd0, ok_tx_bl}, 32'd0);
                chk("en_tx_bl_fall", {31'd0, en_tx_bl}, 32'd0);
            end
        end
        mon_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && en_tx_bl === 1'b1 && exp_len_q.size() > 0) run_block();
        end
    end

    // driver
    task automatic issue(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a);
        @(negedge clk);
        com = c;
        lbl = l;
        adr = a;
        st  = 1'b1;
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a,
                              input bit stray);
        int          n;
        logic [15:0] crc;
        logic [7:0]  bytes[$];
        bit          done, seen;
        exp_q.delete();
        exp_len_q.delete();
        exp_start_q.delete();
        exp_rdadr_q.delete();
        n = (c == 8'h80 || c == 8'h81) ? int'(l) : 0;
        bytes = {c, l, a[15:8], a[7:0]};
        for (int k = 0; k < n; k++) bytes.push_back(mem[16'(a + k)]);
        crc = `INIT_CRC;
        foreach (bytes[i]) crc = crc_byte(crc, bytes[i]);
        bytes.push_back(crc[7:0]);
        bytes.push_back(crc[15:8]);
        foreach (bytes[i]) exp_q.push_back(bytes[i]);
        exp_len_q.push_back(bytes.size());
        exp_rdadr_q.push_back(16'(a + n));
        @(negedge clk);
        exp_start_q.push_back(cyc + 1);
        com = c;
        lbl = l;
        adr = a;
        st  = 1'b1;
        @(negedge clk);
        st = 1'b0;
        if (stray) begin
            // Extra request while the block runs; it must change nothing.
            seen = 1'b0;
            for (int k = 0; k < 40 * NT && !seen; k++) begin
                if (cb_byte == 8'd3) seen = 1'b1;
                else @(negedge clk);
            end
            com = ~c;
            lbl = l + 8'd7;
            adr = ~a;
            st  = 1'b1;
            @(negedge clk);
            st = 1'b0;
        end
        done = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 10 * (6 + n) * NT + G + 200 && !done; k++) begin
            if (!en_tx_bl && !mon_busy) done = 1'b1;
            else @(negedge clk);
        end
        chk("block_complete", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_UTXD"}, {31'd0, UTXD}, 32'd1);
        chk({tag, "_en_tx_bl"}, {31'd0, en_tx_bl}, 32'd0);
        chk({tag, "_en_tx_byte"}, {31'd0, en_tx_byte}, 32'd0);
        chk({tag, "_ok_tx_bl"}, {31'd0, ok_tx_bl}, 32'd0);
        chk({tag, "_cb_byte"}, {24'd0, cb_byte}, 32'd0);
        chk({tag, "_rd_adr"}, {16'd0, rd_adr}, 32'd0);
    endtask

    logic [7:0] rc;
    initial begin
        rst = 1'b1;
        st  = 1'b0;
        com = '0;
        lbl = '0;
        adr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h00FF] = 8'hA5;
        mem[16'h0100] = 8'h3C;
        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_block(8'h80, 8'd2, 16'h00FF, 1'b0);   // read block with known data
        send_block(8'h01, 8'd4, 16'h4321, 1'b0);   // non-read: header + CRC only
        send_block(8'h81, 8'd2, 16'hFFFF, 1'b0);   // address wrap
        send_block(8'h80, 8'd0, 16'h1000, 1'b0);   // zero-length read
        send_block(8'h81, 8'd5, 16'h2000, 1'b1);   // stray st during byte 3

        // Reset in the middle of data bit 4 of byte 1.
        mon_en = 1'b0;
        issue(8'h80, 8'd3, 16'h1234);
        repeat (15 * NT + 1) @(negedge clk);
        chk("pre_rst_en_tx_bl", {31'd0, en_tx_bl}, 32'd1);
        rst = 1'b1;
        st  = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        @(negedge clk);
        st = 1'b0;
        chk("st_during_rst", {31'd0, en_tx_bl}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_UTXD", {31'd0, UTXD}, 32'd1);
        mon_en = 1'b1;
        send_block(8'h80, 8'd3, 16'h1234, 1'b0);   // fresh block after reset

        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 3))
                0:       rc = 8'h80;
                1:       rc = 8'h81;
                default: rc = 8'($urandom);
            endcase
            send_block(rc, 8'($urandom_range(0, 24)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        send_block(8'h81, 8'd255, 16'($urandom), 1'b0);   // longest block, cb_byte wraps

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
